play_core: RTL and testbench
============================

Name: play_core

Overview:
Playback stage directly downstream of the recorder in the mix datapath. It consumes clips stored in SDRAM in the recorder's layout: a length word at the base address, then one 32-bit sample per word at base+1 .. base+L. The block fetches the clip through the shared SDRAM read handshake, buffers samples in a small FIFO and streams them to the audio DAC path with a valid/ready handshake. It supports pause, stop and loop under controller command and reports completion with play_done.

Parameters:
FIFO_DEPTH, 4, sample prefetch buffer entries; power of two, minimum 2
ADDR_W, 23, SDRAM word address width

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
play_start  in  1  single-cycle pulse; begin playback of clip at play_select
play_select  in  ADDR_W  clip base address (length word); sampled only on accepted start
play_pause  in  1  level; while high, no new reads are issued and audio output is held
play_stop  in  1  single-cycle pulse; abort playback
play_loop  in  1  level; sampled at end of each pass
play_done  out  1  single-cycle pulse when playback ends (normal end, stop, or zero length)
play_busy  out  1  high in every state except IDLE
play_read  out  1  SDRAM read request; held until play_sdram_finished
play_addr  out  ADDR_W  SDRAM word address; stable while play_read is high
play_readdata  in  32  SDRAM read data; valid in the cycle play_sdram_finished is high
play_write  out  1  tied 0
play_writedata  out  32  tied 0
play_sdram_finished  in  1  single-cycle completion pulse for the current request
play_audio_data  out  32  FIFO head sample
play_audio_valid  out  1  sample available
play_audio_ready  in  1  DAC side accepts; transfer occurs when valid and ready are both high

Behaviour:
- Reset: state IDLE; FIFO empty; all outputs 0; internal base, len, remaining and addr registers 0.
- States:
  - IDLE: play_start latches base=play_select and moves to READ_LEN. play_read rises the next cycle.
  - READ_LEN: play_read=1, play_addr=base. On finished, len=play_readdata[ADDR_W-1:0] and bits 31:ADDR_W are ignored. If len==0, pulse play_done and go to IDLE. Otherwise set addr=base+1, remaining=len and go to FETCH.
  - FETCH: a read is issued only when count<FIFO_DEPTH, remaining!=0, play_pause is low and no stop is pending. Once issued, play_read stays high until finished. On finished, push play_readdata, increment addr, decrement remaining. When remaining reaches 0, go to DRAIN.
  - DRAIN: wait for the FIFO to empty. If play_loop is high at that cycle, set addr=base+1, remaining=len and return to FETCH. Otherwise pulse play_done and go to IDLE.
- Pause: a read already in flight completes and its data is pushed.
- Address arithmetic wraps modulo 2^ADDR_W (base 0x7FFFFF gives first sample at 0x000000).
- play_audio_valid = FIFO non-empty AND play_pause low AND state != IDLE.
- Pop when valid && ready. A push and a pop in the same cycle leave count unchanged. Because a read is issued only with a free entry, a push never overflows.
- Stop in a non-IDLE state sets stop_pending:
  - If no read is outstanding, the following cycle flushes the FIFO, pulses play_done and goes to IDLE.
  - If a read is outstanding, play_read stays high until finished. The returned data is discarded, then the block flushes the FIFO, pulses done and goes to IDLE.
- play_start while busy is ignored. play_stop while IDLE is ignored and produces no done pulse.
- play_start and play_stop in the same IDLE cycle: the start is accepted and the stop is ignored.
- Reset mid-read: the request drops immediately. The SDRAM arbiter is responsible for discarding the orphaned completion.

Test Plan:
1. mem[0x100]=3, mem[0x101..0x103]=A,B,C, ready=1, finished 2 cycles after each request -> reads 0x100,0x101,0x102,0x103 in order; audio outputs A,B,C; exactly one play_done after C transfers; no read of 0x104.
2. mem[0x200]=0 -> single read of 0x200, play_done pulse, play_audio_valid never high, play_busy low afterwards.
3. len=10, ready=0, depth 4 -> exactly 4 sample reads after the length read, then play_read stays low. Raise ready -> remaining 6 fetched; output order matches memory.
4. Pause high after second sample transfers -> valid low and no new read issue within 1 cycle. Release -> third sample follows; no sample lost or duplicated.
5. Stop while read of 0x105 is outstanding, finished delayed 5 cycles -> play_read held until finished, data discarded, play_done one cycle later, FIFO empty. A new start then plays correctly.
6. len=2 (A,B), loop=1 -> A,B,A,B,... with one length read only. Drop loop during a pass -> that pass completes, then play_done. Also run base=0x7FFFFF -> first sample read at 0x000000.

Source files
------------

// File: rtl/play_core.sv
// Clip playback: fetches a length-prefixed clip from SDRAM into a small FIFO and streams it to the DAC.
// Latency: first sample valid 1 cycle after its SDRAM completion; one SDRAM request in flight at a time.
// Backpressure: reads stall while the FIFO is full or paused; output holds while play_audio_ready is low.
module play_core #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 23
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              play_start,
  input  logic [ADDR_W-1:0] play_select,
  input  logic              play_pause,
  input  logic              play_stop,
  input  logic              play_loop,
  output logic              play_done,
  output logic              play_busy,
  output logic              play_read,
  output logic [ADDR_W-1:0] play_addr,
  input  logic [31:0]       play_readdata,
  output logic              play_write,
  output logic [31:0]       play_writedata,
  input  logic              play_sdram_finished,
  output logic [31:0]       play_audio_data,
  output logic              play_audio_valid,
  input  logic              play_audio_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ_LEN,
    ST_FETCH,
    ST_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              read_q, read_d;
  logic              stop_pend_q, stop_pend_d;
  logic              done_q, done_d;

  logic [31:0]       fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              push;
  logic              pop;
  logic              flush;
  logic              end_play;

  assign play_busy        = (state_q != ST_IDLE);
  assign play_read        = read_q;
  assign play_done        = done_q;
  assign play_addr        = (state_q == ST_READ_LEN) ? base_q : addr_q;
  assign play_write       = 1'b0;
  assign play_writedata   = '0;
  assign play_audio_valid = (count_q != '0) && !play_pause && (state_q != ST_IDLE);
  assign play_audio_data  = (count_q != '0) ? fifo_mem_q[rd_ptr_q] : '0;
  assign pop              = play_audio_valid && play_audio_ready;

  // Playback sequencing: length fetch, sample prefetch, drain/loop, and stop handling.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    rem_d       = rem_q;
    addr_d      = addr_q;
    read_d      = read_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;
    push        = 1'b0;
    end_play    = 1'b0;

    if (play_stop && (state_q != ST_IDLE)) begin
      stop_pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        // A simultaneous stop is meaningless here: the start wins.
        if (play_start) begin
          base_d      = play_select;
          read_d      = 1'b1;
          stop_pend_d = 1'b0;
          state_d     = ST_READ_LEN;
        end
      end
      ST_READ_LEN: begin
        if (play_sdram_finished) begin
          read_d = 1'b0;
          if (stop_pend_q || (play_readdata[ADDR_W-1:0] == '0)) begin
            end_play = 1'b1;
          end else begin
            len_d   = play_readdata[ADDR_W-1:0];
            rem_d   = play_readdata[ADDR_W-1:0];
            addr_d  = base_q + ADDR_W'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (read_q) begin
          if (play_sdram_finished) begin
            read_d = 1'b0;
            if (stop_pend_q) begin
              // Data returned for an aborted clip is dropped.
              end_play = 1'b1;
            end else begin
              push   = 1'b1;
              addr_d = addr_q + ADDR_W'(1);
              rem_d  = rem_q - ADDR_W'(1);
              if (rem_q == ADDR_W'(1)) begin
                state_d = ST_DRAIN;
              end
            end
          end
        end else if (stop_pend_q) begin
          end_play = 1'b1;
        end else if ((count_q < DEPTH_C) && (rem_q != '0) && !play_pause) begin
          // Issue only with a free entry so the returning push can never overflow.
          read_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (stop_pend_q) begin
          end_play = 1'b1;
        end else if (count_q == '0) begin
          if (play_loop) begin
            addr_d  = base_q + ADDR_W'(1);
            rem_d   = len_q;
            state_d = ST_FETCH;
          end else begin
            end_play = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (end_play) begin
      state_d     = ST_IDLE;
      done_d      = 1'b1;
      read_d      = 1'b0;
      stop_pend_d = 1'b0;
    end
  end

  assign flush = end_play;

  // FIFO pointer and occupancy update; flush on any end of playback.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control and FIFO bookkeeping registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      rem_q       <= '0;
      addr_q      <= '0;
      read_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      rem_q       <= rem_d;
      addr_q      <= addr_d;
      read_q      <= read_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Sample storage; contents are only meaningful below count_q.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= play_readdata;
    end
  end

endmodule

// File: tb/tb_play_core.sv
`timescale 1ns/1ps
module tb_play_core;
  localparam int AW = 23;
  localparam int unsigned MASK = 32'h007F_FFFF;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          play_start, play_pause, play_stop, play_loop;
  logic [AW-1:0] play_select;
  logic          play_done, play_busy, play_read, play_write;
  logic [AW-1:0] play_addr;
  logic [31:0]   play_readdata, play_writedata, play_audio_data;
  logic          play_sdram_finished, play_audio_valid, play_audio_ready;

  always #5 i_clk = ~i_clk;

  play_core #(.FIFO_DEPTH(4), .ADDR_W(AW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .play_start(play_start), .play_select(play_select),
    .play_pause(play_pause), .play_stop(play_stop), .play_loop(play_loop),
    .play_done(play_done), .play_busy(play_busy),
    .play_read(play_read), .play_addr(play_addr), .play_readdata(play_readdata),
    .play_write(play_write), .play_writedata(play_writedata),
    .play_sdram_finished(play_sdram_finished),
    .play_audio_data(play_audio_data), .play_audio_valid(play_audio_valid),
    .play_audio_ready(play_audio_ready)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bench-side memory and expected-sample scoreboard.
  logic [31:0] mem [int unsigned];
  logic [31:0] exp_q [$];
  logic [AW-1:0] rd_log [$];

  function automatic logic [31:0] sval(input int unsigned base, input int unsigned i);
    return 32'h5A00_0000 ^ ((base << 8) + i);
  endfunction

  function automatic logic [31:0] memrd(input logic [AW-1:0] a);
    int unsigned k;
    k = 32'(a);
    if (mem.exists(k)) return mem[k];
    return 32'hBAD0_0000 | k;
  endfunction

  task automatic load_clip(input int unsigned base, input int unsigned len);
    mem[base & MASK] = len;
    for (int i = 1; i <= int'(len); i++) mem[(base + i) & MASK] = sval(base, i);
  endtask

  task automatic push_exp(input int unsigned base, input int unsigned len, input int passes);
    for (int p = 0; p < passes; p++)
      for (int i = 1; i <= int'(len); i++) exp_q.push_back(sval(base, i));
  endtask

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // SDRAM responder: one request at a time, completion resp_lat samples after it is seen.
  int            resp_lat = 2;
  int            resp_cnt;
  logic          resp_active = 1'b0;
  logic [AW-1:0] resp_addr;
  int            fin_cyc = 0;
  initial begin
    play_sdram_finished = 1'b0;
    play_readdata = '0;
    forever begin
      @(posedge i_clk); #1;
      if (play_sdram_finished) begin
        play_sdram_finished = 1'b0;
        play_readdata = '0;
        resp_active = 1'b0;
      end else if (resp_active) begin
        check_eq("read_held", play_read, 1'b1);
        check_eq("addr_stable", play_addr, resp_addr);
        if (resp_cnt <= 1) begin
          play_sdram_finished = 1'b1;
          play_readdata = memrd(resp_addr);
          fin_cyc = cyc;
        end else begin
          resp_cnt--;
        end
      end else if (play_read && !i_rst) begin
        resp_active = 1'b1;
        resp_addr = play_addr;
        resp_cnt = resp_lat;
        rd_log.push_back(play_addr);
      end
    end
  end

  // Output monitor: transfers checked against the scoreboard, done pulses counted.
  int xfer_cnt = 0, done_cnt = 0, valid_cnt = 0, done_cyc = 0;
  always @(negedge i_clk) begin
    if (play_audio_valid) valid_cnt <= valid_cnt + 1;
    if (play_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (play_audio_valid && play_audio_ready) begin
      xfer_cnt <= xfer_cnt + 1;
      check_eq("sb_avail", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check_eq("sample", play_audio_data, exp_q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge i_clk); #2; end
  endtask

  task automatic start_clip(input int unsigned base, input logic with_stop);
    play_select = AW'(base);
    play_start = 1'b1;
    play_stop = with_stop;
    tick(1);
    play_start = 1'b0;
    play_stop = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0, k;
    d0 = done_cnt;
    k = 0;
    while (done_cnt == d0 && k < budget) begin tick(1); k++; end
    check_eq({tag, "_done"}, done_cnt != d0, 1'b1);
    check_eq({tag, "_sb_drained"}, exp_q.size(), 0);
    tick(3);
    check_eq({tag, "_one_done"}, done_cnt - d0, 1);
    check_eq({tag, "_idle"}, play_busy, 1'b0);
  endtask

  initial begin
    int r0, x0, v0, d0, k, found;
    i_rst = 1'b1;
    play_start = 0; play_stop = 0; play_pause = 0; play_loop = 0;
    play_select = '0; play_audio_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_eq("rst_busy", play_busy, 1'b0);
    check_eq("rst_read", play_read, 1'b0);
    check_eq("rst_valid", play_audio_valid, 1'b0);
    check_eq("rst_done", play_done, 1'b0);
    check_eq("rst_addr", play_addr, 0);
    check_eq("rst_data", play_audio_data, 0);
    check_eq("rst_write", {play_write, play_writedata}, 0);
    @(posedge i_clk); #2;
    i_rst = 1'b0;
    tick(2);

    // 1: basic 3-sample clip
    load_clip(32'h100, 3);
    push_exp(32'h100, 3, 1);
    r0 = rd_log.size();
    start_clip(32'h100, 1'b0);
    wait_done("t1", 300);
    check_eq("t1_nreads", rd_log.size() - r0, 4);
    for (int i = 0; i < 4 && r0 + i < rd_log.size(); i++)
      check_eq("t1_addr", rd_log[r0 + i], 32'h100 + i);

    // 2: zero-length clip
    mem[32'h200] = 32'h0;
    r0 = rd_log.size();
    v0 = valid_cnt;
    start_clip(32'h200, 1'b0);
    wait_done("t2", 100);
    check_eq("t2_nreads", rd_log.size() - r0, 1);
    if (rd_log.size() > r0) check_eq("t2_addr", rd_log[r0], 32'h200);
    check_eq("t2_no_valid", valid_cnt - v0, 0);

    // Stop while idle produces nothing
    d0 = done_cnt;
    play_stop = 1'b1; tick(1); play_stop = 1'b0;
    tick(5);
    check_eq("idle_stop_nodone", done_cnt - d0, 0);
    check_eq("idle_stop_busy", play_busy, 1'b0);

    // 3: backpressure fills FIFO; upper length bits ignored; start while busy ignored
    load_clip(32'h300, 10);
    mem[32'h300] = 32'hFF80_000A;
    push_exp(32'h300, 10, 1);
    play_audio_ready = 1'b0;
    r0 = rd_log.size();
    start_clip(32'h300, 1'b0);
    tick(60);
    check_eq("t3_stall_reads", rd_log.size() - r0, 5);
    check_eq("t3_read_low", play_read, 1'b0);
    check_eq("t3_busy", play_busy, 1'b1);
    start_clip(32'h200, 1'b0);
    tick(10);
    check_eq("t3_start_ignored", rd_log.size() - r0, 5);
    play_audio_ready = 1'b1;
    wait_done("t3", 400);
    check_eq("t3_nreads", rd_log.size() - r0, 11);
    check_eq("t3_last_addr", rd_log[rd_log.size() - 1], 32'h30A);

    // 4: pause after the second transfer
    load_clip(32'h400, 6);
    push_exp(32'h400, 6, 1);
    x0 = xfer_cnt;
    start_clip(32'h400, 1'b0);
    k = 0;
    while (xfer_cnt < x0 + 2 && k < 200) begin tick(1); k++; end
    check_eq("t4_two_xfers", xfer_cnt - x0, 2);
    play_pause = 1'b1;
    @(negedge i_clk);
    check_eq("t4_valid_low", play_audio_valid, 1'b0);
    tick(1);
    r0 = rd_log.size();
    v0 = valid_cnt;
    tick(15);
    check_eq("t4_no_read", rd_log.size() - r0, 0);
    check_eq("t4_held", valid_cnt - v0, 0);
    play_pause = 1'b0;
    wait_done("t4", 400);
    check_eq("t4_xfers", xfer_cnt - x0, 6);

    // 5: stop while read of 0x105 is outstanding
    load_clip(32'h100, 8);
    push_exp(32'h100, 4, 1);
    resp_lat = 5;
    r0 = rd_log.size();
    start_clip(32'h100, 1'b0);
    found = 0;
    k = 0;
    while (!found && k < 300) begin
      tick(1); k++;
      if (resp_active && resp_addr == AW'(32'h105)) found = 1;
    end
    check_eq("t5_found_105", found, 1);
    play_stop = 1'b1; tick(1); play_stop = 1'b0;
    wait_done("t5", 100);
    check_eq("t5_done_lat", done_cyc - fin_cyc, 1);
    check_eq("t5_nreads", rd_log.size() - r0, 6);
    check_eq("t5_valid", play_audio_valid, 1'b0);
    resp_lat = 2;
    load_clip(32'h500, 2);
    push_exp(32'h500, 2, 1);
    x0 = xfer_cnt;
    start_clip(32'h500, 1'b0);
    wait_done("t5b", 200);
    check_eq("t5b_xfers", xfer_cnt - x0, 2);

    // Start and stop together in IDLE: start wins
    load_clip(32'h600, 1);
    push_exp(32'h600, 1, 1);
    x0 = xfer_cnt;
    start_clip(32'h600, 1'b1);
    wait_done("ss", 200);
    check_eq("ss_xfers", xfer_cnt - x0, 1);

    // 6: loop, then drop loop mid-pass
    load_clip(32'h700, 2);
    push_exp(32'h700, 2, 3);
    play_loop = 1'b1;
    x0 = xfer_cnt;
    r0 = rd_log.size();
    start_clip(32'h700, 1'b0);
    k = 0;
    while (xfer_cnt < x0 + 5 && k < 400) begin tick(1); k++; end
    check_eq("t6_five_xfers", xfer_cnt - x0, 5);
    play_loop = 1'b0;
    wait_done("t6", 200);
    check_eq("t6_xfers", xfer_cnt - x0, 6);
    check_eq("t6_nreads", rd_log.size() - r0, 7);
    found = 0;
    for (int i = r0; i < rd_log.size(); i++) if (rd_log[i] == AW'(32'h700)) found++;
    check_eq("t6_len_reads", found, 1);

    // Address wrap
    load_clip(32'h7F_FFFF, 1);
    push_exp(32'h7F_FFFF, 1, 1);
    r0 = rd_log.size();
    start_clip(32'h7F_FFFF, 1'b0);
    wait_done("wrap", 200);
    check_eq("wrap_nreads", rd_log.size() - r0, 2);
    if (rd_log.size() > r0 + 1) check_eq("wrap_addr", rd_log[r0 + 1], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
